// File: rtl/img_pkg.sv
// img_pkg: shared definitions for the UART image loader.
//   - state_t   : loader FSM encoding (3 bits, S_IDLE..S_DONE)
//   - PIXEL_W   : RAM word width ({R,G,B})
//   - R/G/B_LSB : bit offset of each colour byte inside a pixel word
package img_pkg;

  localparam int unsigned PIXEL_W = 24;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned STATE_W = 3;

  localparam int unsigned R_LSB = 16;
  localparam int unsigned G_LSB = 8;
  localparam int unsigned B_LSB = 0;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_R    = 3'd1,
    S_G    = 3'd2,
    S_B    = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // States in which a FIFO byte may be consumed.
  function automatic logic is_collect(input state_t s);
    return (s == S_R) || (s == S_G) || (s == S_B);
  endfunction

  // States in which an empty FIFO counts toward the partial-pixel timeout.
  function automatic logic is_partial(input state_t s);
    return (s == S_G) || (s == S_B);
  endfunction

endpackage

// File: rtl/rx_timeout_ctr.sv
// rx_timeout_ctr: idle-cycle watchdog for a partially received pixel.
//   Down-counter reloaded with CYCLES-1 while clear is high; decrements while
//   en is high. expire_c is asserted (combinationally) on the CYCLES-th
//   consecutive enabled cycle after a clear.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   clear       : reload the counter
//   en          : count this cycle
//   expire_c    : timeout reached in this cycle
module rx_timeout_ctr #(
  parameter int unsigned CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Remaining idle cycles; the reset value is overwritten by the reload that
  // is active in every state outside a partial pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire_c = en && (cnt == '0);

endmodule

// File: rtl/img_uart_loader.sv
// img_uart_loader: drains the UART receive FIFO, packs bytes into 24-bit
// {R,G,B} pixels and writes IMG_PIXELS of them sequentially into the source
// image RAM, then reports done.
// Configuration macro: GRAY_REPLICATE_EN -- when defined, every byte is one
//   greyscale pixel written as {b,b,b}; S_G/S_B and the timeout are unused.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start      : single-cycle load command (honoured in S_IDLE/S_DONE only)
//   rx_empty   : FIFO empty flag
//   r_data     : FIFO head byte (first-word fall-through)
//   rd_uart    : FIFO pop, combinational from state and rx_empty
//   we, addr, DI : RAM write port (registered)
//   busy, done : load in progress / image complete (registered)
//   resync     : one-cycle pulse when a partial pixel is abandoned
module img_uart_loader
  import img_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = 10,
  parameter int unsigned IMG_PIXELS     = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 rx_empty,
  input  logic [7:0]           r_data,
  output logic                 rd_uart,
  output logic                 we,
  output logic [ADDR_BITS-1:0] addr,
  output logic [23:0]          DI,
  output logic                 busy,
  output logic                 done,
  output logic                 resync
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(IMG_PIXELS - 1);

  state_t state;
  logic   tmo_clear;
  logic   tmo_en;
  logic   tmo_expire_c;

  // A byte is consumed whenever one is waiting and a colour slot is open.
  assign rd_uart = is_collect(state) && !rx_empty;

`ifdef GRAY_REPLICATE_EN
  assign tmo_en    = 1'b0;
  assign tmo_clear = 1'b1;
`else
  assign tmo_en    = is_partial(state) && rx_empty;
  assign tmo_clear = !is_partial(state) || !rx_empty;
`endif

  rx_timeout_ctr #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmo_clear),
    .en       (tmo_en),
    .expire_c (tmo_expire_c)
  );

  // Loader FSM with registered RAM port and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      addr   <= '0;
      DI     <= '0;
      we     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      resync <= 1'b0;
    end else begin
      we     <= 1'b0;
      resync <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_R;
            addr  <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
          end
        end

        S_R: begin
          if (!rx_empty) begin
`ifdef GRAY_REPLICATE_EN
            DI    <= {3{r_data}};
            state <= S_WR;
            we    <= 1'b1;
`else
            DI[R_LSB +: BYTE_W] <= r_data;
            state <= S_G;
`endif
          end
        end

        // Stale lanes left by an abandoned pixel are always overwritten
        // before the next S_WR, so expiry only needs to restart at S_R.
        S_G: begin
          if (!rx_empty) begin
            DI[G_LSB +: BYTE_W] <= r_data;
            state <= S_B;
          end else if (tmo_expire_c) begin
            state  <= S_R;
            resync <= 1'b1;
          end
        end

        S_B: begin
          if (!rx_empty) begin
            DI[B_LSB +: BYTE_W] <= r_data;
            state <= S_WR;
            we    <= 1'b1;
          end else if (tmo_expire_c) begin
            state  <= S_R;
            resync <= 1'b1;
          end
        end

        S_WR: begin
          if (addr == LAST_ADDR) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            addr  <= addr + ADDR_BITS'(1);
            state <= S_R;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_uart_loader.sv
// tb_img_uart_loader: directed bench for img_uart_loader with a write
// scoreboard (expected {addr,DI} pushed when a pixel's last byte is driven,
// popped on every we pulse).
module tb_img_uart_loader;

  localparam int unsigned ADDR_BITS = 10;
`ifdef GRAY_REPLICATE_EN
  localparam int unsigned NPIX = 3;
`else
  localparam int unsigned NPIX = 4;
`endif
  localparam int unsigned TMO = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 rx_empty;
  logic [7:0]           r_data;
  logic                 rd_uart;
  logic                 we;
  logic [ADDR_BITS-1:0] addr;
  logic [23:0]          DI;
  logic                 busy;
  logic                 done;
  logic                 resync;

  always #5 clk = ~clk;

  img_uart_loader #(
    .ADDR_BITS      (ADDR_BITS),
    .IMG_PIXELS     (NPIX),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_empty (rx_empty),
    .r_data   (r_data),
    .rd_uart  (rd_uart),
    .we       (we),
    .addr     (addr),
    .DI       (DI),
    .busy     (busy),
    .done     (done),
    .resync   (resync)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int resync_cnt = 0;
  int last_we_cyc = -100;
  int done_rise_cyc = -1;
  logic prev_done = 1'b0;
  logic [ADDR_BITS+23:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: sampled 1 time unit after each active edge.
  always @(posedge clk) begin
    logic [ADDR_BITS+23:0] e;
    #1;
    check("rd_when_empty", 32'(rd_uart & rx_empty), 32'(0));
    if (we) begin
      last_we_cyc = cyc;
      check("write_expected", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("wr_addr", 32'(addr), 32'(e[ADDR_BITS+23:24]));
        check("wr_data", 32'(DI), 32'(e[23:0]));
      end
    end
    if (resync) resync_cnt = resync_cnt + 1;
    if (done && !prev_done) done_rise_cyc = cyc;
    prev_done = done;
  end

  // Present one byte after `gap` empty cycles and hold it until popped.
  task automatic send(input logic [7:0] b, input int gap);
    bit got = 1'b0;
    for (int i = 0; i < gap; i++) begin
      rx_empty = 1'b1;
      @(negedge clk);
    end
    rx_empty = 1'b0;
    r_data   = b;
    for (int t = 0; t < 50 && !got; t++) begin
      #1;
      if (rd_uart) begin
        got = 1'b1;
        rd_cnt++;
      end
      @(negedge clk);
    end
    rx_empty = 1'b1;
    check("byte_accepted", 32'(got), 32'(1));
  endtask

  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input int gap, input logic [ADDR_BITS-1:0] a);
    send(r, gap);
    send(g, gap);
    sb.push_back({a, r, g, b});
    send(b, gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    check("done_set", 32'(done), 32'(1));
    check("busy_clr", 32'(busy), 32'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, 32'(we), 32'(0));
    check({tag, "_addr"}, 32'(addr), 32'(0));
    check({tag, "_DI"}, 32'(DI), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_resync"}, 32'(resync), 32'(0));
    check({tag, "_rd_uart"}, 32'(rd_uart), 32'(0));
  endtask

  initial begin
    int rd_base;
    int rs_base;
    reset    = 1'b1;
    start    = 1'b0;
    rx_empty = 1'b1;
    r_data   = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

`ifdef GRAY_REPLICATE_EN
    rd_base = rd_cnt;
    pulse_start();
    check("gray_busy", 32'(busy), 32'(1));
    sb.push_back({10'd0, 24'h101010});
    send(8'h10, 0);
    sb.push_back({10'd1, 24'h808080});
    send(8'h80, 0);
    sb.push_back({10'd2, 24'hFFFFFF});
    send(8'hFF, 3);
    wait_done();
    check("gray_rd_count", 32'(rd_cnt - rd_base), 32'(3));
    check("gray_sb_empty", 32'(sb.size()), 32'(0));
    check("gray_resync", 32'(resync_cnt), 32'(0));
`else
    // Back-to-back load of four pixels.
    pulse_start();
    check("t1_busy", 32'(busy), 32'(1));
    check("t1_done", 32'(done), 32'(0));
    send_pixel(8'h11, 8'h22, 8'h33, 0, 10'd0);
    send_pixel(8'h44, 8'h55, 8'h66, 0, 10'd1);
    send_pixel(8'h77, 8'h88, 8'h99, 0, 10'd2);
    send_pixel(8'hAA, 8'hBB, 8'hCC, 0, 10'd3);
    wait_done();
    check("t1_done_latency", 32'(done_rise_cyc), 32'(last_we_cyc + 1));
    check("t1_sb_empty", 32'(sb.size()), 32'(0));

    // Slow feed: 7 idle cycles before every byte (one short of expiry),
    // with an ignored start while a pixel is in progress.
    rd_base = rd_cnt;
    rs_base = resync_cnt;
    pulse_start();
    send_pixel(8'h11, 8'h22, 8'h33, 7, 10'd0);
    send_pixel(8'h44, 8'h55, 8'h66, 7, 10'd1);
    send(8'h77, 7);
    pulse_start();
    check("t2_start_ignored_busy", 32'(busy), 32'(1));
    send(8'h88, 6);
    sb.push_back({10'd2, 24'h778899});
    send(8'h99, 7);
    send_pixel(8'hAA, 8'hBB, 8'hCC, 7, 10'd3);
    wait_done();
    check("t2_rd_count", 32'(rd_cnt - rd_base), 32'(12));
    check("t2_no_resync", 32'(resync_cnt - rs_base), 32'(0));
    check("t2_sb_empty", 32'(sb.size()), 32'(0));

    // Restart from S_DONE, then let a partial pixel time out.
    rs_base = resync_cnt;
    pulse_start();
    check("t3_done_clr", 32'(done), 32'(0));
    check("t3_busy", 32'(busy), 32'(1));
    send(8'h01, 0);
    send(8'h02, 0);
    send(8'hA1, 8);
    check("t3_resync_once", 32'(resync_cnt - rs_base), 32'(1));
    send(8'hB2, 0);
    sb.push_back({10'd0, 24'hA1B2C3});
    send(8'hC3, 0);
    check("t3_sb_empty", 32'(sb.size()), 32'(0));
    check("t3_resync_total", 32'(resync_cnt - rs_base), 32'(1));

    // Asynchronous reset in the middle of pixel 1 (bytes 4 and 5 of 12).
    send(8'h44, 0);
    send(8'h55, 0);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("postreset");
    pulse_start();
    send_pixel(8'h5A, 8'h6B, 8'h7C, 0, 10'd0);
    send_pixel(8'h01, 8'h02, 8'h03, 1, 10'd1);
    send_pixel(8'hFE, 8'hDC, 8'hBA, 0, 10'd2);
    send_pixel(8'h00, 8'hFF, 8'h80, 2, 10'd3);
    wait_done();
    check("t4_addr_hold", 32'(addr), 32'(3));
    check("t4_sb_empty", 32'(sb.size()), 32'(0));
`endif

    repeat (3) @(negedge clk);
    check("final_we_low", 32'(we), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
